// File: rtl/reg_univ.sv
`default_nettype none
// ============================================================================
//  Module   : reg_univ
//  Purpose  : Parametrised universal register. Parallel load, shift left/right
//             with serial input, rotate left/right, and up/down count with a
//             combinational terminal-count and a registered sticky wrap flag.
//  Ports    : in_CLK   - clock, rising edge active
//             in_RST   - asynchronous active-high reset
//             in_EN    - enable; all state holds when low
//             in_MODE  - operation select (HOLD/LOAD/SHL/SHR/ROL/ROR/UP/DOWN)
//             in_D     - parallel load data
//             in_SI    - serial input for shifts
//             out_Q    - register contents
//             out_SO_L - out_Q[WIDTH-1] (bit leaving on a left shift)
//             out_SO_R - out_Q[0]       (bit leaving on a right shift)
//             out_TC   - terminal count (next enabled edge wraps the counter)
//             out_OVF  - sticky wrap flag, cleared by LOAD or reset
//  Revision : 1.0 - initial release
// ============================================================================
module reg_univ #(
   parameter int               WIDTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             in_CLK,
   input  logic             in_RST,
   input  logic             in_EN,
   input  logic [2:0]       in_MODE,
   input  logic [WIDTH-1:0] in_D,
   input  logic             in_SI,
   output logic [WIDTH-1:0] out_Q,
   output logic             out_SO_L,
   output logic             out_SO_R,
   output logic             out_TC,
   output logic             out_OVF
);

   localparam logic [2:0] c_mode_hold = 3'b000;
   localparam logic [2:0] c_mode_load = 3'b001;
   localparam logic [2:0] c_mode_shl  = 3'b010;
   localparam logic [2:0] c_mode_shr  = 3'b011;
   localparam logic [2:0] c_mode_rol  = 3'b100;
   localparam logic [2:0] c_mode_ror  = 3'b101;
   localparam logic [2:0] c_mode_up   = 3'b110;
   localparam logic [2:0] c_mode_down = 3'b111;

   localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             ovf_q;
   logic             ovf_d;
   logic             w_tc;

   // Terminal count is gated by enable so it only flags an edge that will
   // actually wrap the counter.
   always_comb begin
      w_tc = 1'b0;
      if (in_EN) begin
         if ((in_MODE == c_mode_up) && (&q_q)) begin
            w_tc = 1'b1;
         end else if ((in_MODE == c_mode_down) && (q_q == '0)) begin
            w_tc = 1'b1;
         end
      end
   end

   always_comb begin
      q_d   = q_q;
      ovf_d = ovf_q;
      if (in_EN) begin
         case (in_MODE)
            c_mode_hold: q_d = q_q;
            c_mode_load: begin
               q_d   = in_D;
               ovf_d = 1'b0;
            end
            c_mode_shl:  q_d = {q_q[WIDTH-2:0], in_SI};
            c_mode_shr:  q_d = {in_SI, q_q[WIDTH-1:1]};
            c_mode_rol:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            c_mode_ror:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            c_mode_up:   q_d = q_q + c_one;
            c_mode_down: q_d = q_q - c_one;
            default:     q_d = q_q;
         endcase
         // A wrap is only possible in UP/DOWN, never together with LOAD.
         if (w_tc) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge in_CLK or posedge in_RST) begin
      if (in_RST) begin
         q_q   <= RST_VAL;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ovf_q <= ovf_d;
      end
   end

   assign out_Q    = q_q;
   assign out_SO_L = q_q[WIDTH-1];
   assign out_SO_R = q_q[0];
   assign out_TC   = w_tc;
   assign out_OVF  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_univ.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_univ
//  Purpose  : Self-checking bench for reg_univ (WIDTH=3, RST_VAL=3'b101).
//             Directed sequences followed by random traffic, all compared
//             against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_univ;

   localparam int         c_w  = 3;
   localparam logic [2:0] c_rv = 3'b101;

   localparam logic [2:0] c_hold = 3'd0;
   localparam logic [2:0] c_load = 3'd1;
   localparam logic [2:0] c_shl  = 3'd2;
   localparam logic [2:0] c_shr  = 3'd3;
   localparam logic [2:0] c_rol  = 3'd4;
   localparam logic [2:0] c_ror  = 3'd5;
   localparam logic [2:0] c_up   = 3'd6;
   localparam logic [2:0] c_down = 3'd7;

   logic           r_clk  = 1'b0;
   logic           r_rst  = 1'b1;
   logic           r_en   = 1'b0;
   logic [2:0]     r_mode = 3'd0;
   logic [c_w-1:0] r_d    = '0;
   logic           r_si   = 1'b0;
   logic [c_w-1:0] w_q;
   logic           w_so_l;
   logic           w_so_r;
   logic           w_tc;
   logic           w_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: plain integers.
   int m_q   = 5;
   int m_ovf = 0;

   reg_univ #(.WIDTH(c_w), .RST_VAL(c_rv)) u_dut (
      .in_CLK   (r_clk),
      .in_RST   (r_rst),
      .in_EN    (r_en),
      .in_MODE  (r_mode),
      .in_D     (r_d),
      .in_SI    (r_si),
      .out_Q    (w_q),
      .out_SO_L (w_so_l),
      .out_SO_R (w_so_r),
      .out_TC   (w_tc),
      .out_OVF  (w_ovf)
   );

   always #5 r_clk = ~r_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int model_tc(input int e, input int m, input int q);
      if (e == 0) return 0;
      if (m == 6 && q == 7) return 1;
      if (m == 7 && q == 0) return 1;
      return 0;
   endfunction

   // Apply inputs between edges, check the combinational outputs, clock once,
   // then check the registered result.
   task automatic step(input logic e, input logic [2:0] m, input logic [2:0] dd, input logic s);
      int tc;
      int mi;
      int di;
      int si;
      r_en = e; r_mode = m; r_d = dd; r_si = s;
      mi = int'(m); di = int'(dd); si = int'(s);
      #1;
      tc = model_tc(int'(e), mi, m_q);
      chk("tc",   32'(w_tc),   32'(tc));
      chk("so_l", 32'(w_so_l), 32'((m_q >> 2) & 1));
      chk("so_r", 32'(w_so_r), 32'(m_q & 1));
      @(posedge r_clk);
      if (e) begin
         case (mi)
            1: begin m_q = di; m_ovf = 0; end
            2: m_q = ((m_q * 2) + si) % 8;
            3: m_q = (si * 4) + (m_q / 2);
            4: m_q = ((m_q * 2) % 8) + (m_q / 4);
            5: m_q = ((m_q % 2) * 4) + (m_q / 2);
            6: m_q = (m_q + 1) % 8;
            7: m_q = (m_q + 7) % 8;
            default: ;
         endcase
         if (tc == 1) m_ovf = 1;
      end
      #1;
      chk("q",   32'(w_q),   32'(m_q));
      chk("ovf", 32'(w_ovf), 32'(m_ovf));
   endtask

   // Reset pulse between edges; effect must be visible before the next edge.
   task automatic pulse_rst();
      r_rst = 1'b1;
      #1;
      m_q = 5; m_ovf = 0;
      chk("rst_q",   32'(w_q),   32'(5));
      chk("rst_ovf", 32'(w_ovf), 32'(0));
      #1;
      r_rst = 1'b0;
   endtask

   initial begin
      // Reset held across edges with counting requested.
      r_en = 1'b1; r_mode = c_up;
      repeat (2) @(posedge r_clk);
      #1;
      chk("rst_hold_q",   32'(w_q),   32'(5));
      chk("rst_hold_ovf", 32'(w_ovf), 32'(0));
      r_rst = 1'b0;

      // Load then disabled in every mode.
      step(1'b1, c_load, 3'b110, 1'b0);
      chk("load_q", 32'(w_q), 32'(6));
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 3'(i), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         chk("en0_q", 32'(w_q), 32'(6));
      end

      // Shifts and rotates.
      step(1'b1, c_shl, 3'd0, 1'b1);  chk("shl", 32'(w_q), 32'(5));
      step(1'b1, c_shr, 3'd0, 1'b0);  chk("shr", 32'(w_q), 32'(2));
      step(1'b1, c_load, 3'b100, 1'b0);
      step(1'b1, c_rol, 3'd0, 1'b0);  chk("rol", 32'(w_q), 32'(1));
      step(1'b1, c_ror, 3'd0, 1'b0);  chk("ror", 32'(w_q), 32'(4));

      // Count up through the wrap.
      step(1'b1, c_load, 3'b110, 1'b0);
      step(1'b1, c_up, 3'd0, 1'b0);   chk("up7", 32'(w_q), 32'(7));
      r_mode = c_up; #1;
      chk("up_tc", 32'(w_tc), 32'(1));
      step(1'b1, c_up, 3'd0, 1'b0);
      chk("up_wrap_q",   32'(w_q),   32'(0));
      chk("up_wrap_ovf", 32'(w_ovf), 32'(1));
      step(1'b1, c_up, 3'd0, 1'b0);
      chk("up_sticky", 32'(w_ovf), 32'(1));
      step(1'b1, c_load, 3'b000, 1'b0);
      chk("load_clr_ovf", 32'(w_ovf), 32'(0));

      // Count down through the wrap.
      step(1'b1, c_load, 3'b001, 1'b0);
      step(1'b1, c_down, 3'd0, 1'b0); chk("dn0", 32'(w_q), 32'(0));
      r_mode = c_down; #1;
      chk("dn_tc", 32'(w_tc), 32'(1));
      step(1'b1, c_down, 3'd0, 1'b0);
      chk("dn_wrap_q",   32'(w_q),   32'(7));
      chk("dn_wrap_ovf", 32'(w_ovf), 32'(1));
      step(1'b1, c_load, 3'b000, 1'b0);
      r_en = 1'b0; r_mode = c_down; #1;
      chk("dn_tc_en0", 32'(w_tc), 32'(0));
      step(1'b0, c_down, 3'd0, 1'b0);

      // Reset in the middle of counting.
      step(1'b1, c_load, 3'b011, 1'b0);
      pulse_rst();
      step(1'b1, c_up, 3'd0, 1'b0);
      chk("post_rst_up", 32'(w_q), 32'(6));

      // Random traffic against the model.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            pulse_rst();
         end
         step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
